// File: rtl/button_repeat_ctrl.sv
// Pushbutton conditioning: 2-flop sync, debounce, and a per-channel typematic FSM
// producing registered one-cycle inc/dec strobes with dec-over-inc priority.
module button_repeat_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button_inc_n,
  input  logic button_dec_n,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic repeat_active
);

  localparam int unsigned MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_P  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int unsigned CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] DB_LIMIT = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DLY_LOAD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LOAD = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HOLD_WAIT, REPEATING} state_t;

  // Index 0 is the inc channel, index 1 the dec channel.
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    pressed;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    go;
  logic [CW-1:0] db_cnt_q  [2];
  logic [CW-1:0] db_cnt_d  [2];
  logic [CW-1:0] rep_cnt_q [2];
  logic [CW-1:0] rep_cnt_d [2];
  state_t        state_q   [2];
  state_t        state_d   [2];
  logic [1:0]    pulse_q, pulse_d;
  logic          repeat_active_q, repeat_active_d;

  always_comb begin
    sync1_d = {button_dec_n, button_inc_n};
    sync2_d = sync1_q;
    pressed = ~sync2_q;
    deb_d   = deb_q;
    pulse_d = '0;
    // dec owns the strobe path: inc may only run while dec is debounced-released.
    go      = {deb_q[1], deb_q[0] & ~deb_q[1]};

    for (int unsigned i = 0; i < 2; i++) begin
      db_cnt_d[i]  = '0;
      rep_cnt_d[i] = rep_cnt_q[i];
      state_d[i]   = state_q[i];

      // The level flips only after DEBOUNCE_CYCLES+1 consecutive disagreeing samples,
      // which puts the first strobe DEBOUNCE_CYCLES+3 edges after the pin is first sampled.
      if (pressed[i] != deb_q[i]) begin
        if (db_cnt_q[i] >= DB_LIMIT) begin
          deb_d[i] = pressed[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end

      if (!go[i]) begin
        state_d[i]   = IDLE;
        rep_cnt_d[i] = '0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            // Delay count starts with the strobe so repeats land REPEAT_DELAY later.
            state_d[i]   = PRESSED;
            pulse_d[i]   = 1'b1;
            rep_cnt_d[i] = DLY_LOAD;
          end
          PRESSED: begin
            state_d[i] = HOLD_WAIT;
            if (rep_cnt_q[i] != '0) rep_cnt_d[i] = rep_cnt_q[i] - 1'b1;
          end
          HOLD_WAIT, REPEATING: begin
            if (rep_cnt_q[i] == '0) begin
              state_d[i]   = REPEATING;
              pulse_d[i]   = 1'b1;
              rep_cnt_d[i] = PER_LOAD;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] - 1'b1;
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end

    repeat_active_d = (state_q[0] == REPEATING) | (state_q[1] == REPEATING);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q         <= '1;
      sync2_q         <= '1;
      deb_q           <= '0;
      pulse_q         <= '0;
      repeat_active_q <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        db_cnt_q[i]  <= '0;
        rep_cnt_q[i] <= '0;
        state_q[i]   <= IDLE;
      end
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      deb_q           <= deb_d;
      pulse_q         <= pulse_d;
      repeat_active_q <= repeat_active_d;
      for (int unsigned i = 0; i < 2; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
        state_q[i]   <= state_d[i];
      end
    end
  end

  assign inc_pulse     = pulse_q[0];
  assign dec_pulse     = pulse_q[1];
  assign repeat_active = repeat_active_q;

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// Directed bench for button_repeat_ctrl with short timing parameters; cycle n is
// observed 1 time unit after posedge n, with inputs for cycle n applied before it.
module tb_button_repeat_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic button_inc_n = 1'b1;
  logic button_dec_n = 1'b1;
  logic inc_pulse;
  logic dec_pulse;
  logic repeat_active;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int          cyc    = 0;

  button_repeat_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button_inc_n (button_inc_n),
    .button_dec_n (button_dec_n),
    .inc_pulse    (inc_pulse),
    .dec_pulse    (dec_pulse),
    .repeat_active(repeat_active)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    button_inc_n = 1'b1;
    button_dec_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc = -1;
    check_eq("rst_inc", inc_pulse, 1'b0);
    check_eq("rst_dec", dec_pulse, 1'b0);
    check_eq("rst_ra", repeat_active, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic step(input logic ei, input logic ed, input logic era, input string t);
    @(posedge clk);
    #1;
    check_eq({t, "_inc"}, inc_pulse, ei);
    check_eq({t, "_dec"}, dec_pulse, ed);
    check_eq({t, "_ra"}, repeat_active, era);
    check_eq({t, "_excl"}, inc_pulse & dec_pulse, 1'b0);
  endtask

  initial begin
    // 1: inc held -> first strobe, delay, then periodic repeats
    do_reset();
    for (int c = 0; c < 60; c++) begin
      cyc = c;
      button_inc_n = 1'b0;
      button_dec_n = 1'b1;
      step(c inside {7, 27, 35, 43, 51, 59}, 1'b0, c >= 28, "t1");
    end

    // 2: two short bounces rejected, then one clean press gives one strobe
    do_reset();
    for (int c = 0; c < 41; c++) begin
      cyc = c;
      button_inc_n = 1'b1;
      button_dec_n = !((c < 3) || (c >= 5 && c < 8) || (c >= 20 && c < 30));
      step(1'b0, c == 27, 1'b0, "t2");
    end

    // 3: both held, dec wins; inc starts fresh once dec debounces released
    do_reset();
    for (int c = 0; c < 61; c++) begin
      cyc = c;
      button_inc_n = 1'b0;
      button_dec_n = (c >= 40);
      step(c == 47, c inside {7, 27, 35, 43}, (c >= 28 && c <= 47), "t3");
    end

    // 4: reset mid-hold clears outputs and the hold restarts as a fresh press
    do_reset();
    for (int c = 0; c < 46; c++) begin
      cyc = c;
      button_inc_n = 1'b0;
      button_dec_n = 1'b1;
      rst = !(c >= 30 && c < 35);
      step(c inside {7, 27, 42}, 1'b0, (c >= 28 && c <= 29), "t4");
    end
    rst = 1'b1;

    // 5: short press, release, then a dec press
    do_reset();
    for (int c = 0; c < 41; c++) begin
      cyc = c;
      button_inc_n = !(c < 15);
      button_dec_n = !(c >= 25);
      step(c == 7, c == 32, 1'b0, "t5");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
